miriscv_mdu_iter: RTL and testbench

Parametrised multiply/divide unit for the miriscv execute stage, the successor to the fixed 32-bit MDU. It supports XLEN-generic RV M-extension operations with a configurable-latency multiplier and a radix-2/radix-4 iterative divider behind one FSM. Results are held stable across pipeline stalls. It drives the same stall/kill/keep protocol the core pipeline already uses.

---
 rtl/miriscv_mdu_iter.sv | 210 +++++++++++++++++++++
 tb/tb_miriscv_mdu_iter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_mdu_iter.sv
// Iterative RV M-extension unit: counter-timed multiplier and restoring divider behind one FSM.
// Define MIRISCV_MDU_RESULT_CACHE_EN to add a last-result cache that answers repeated requests with no stall.
module miriscv_mdu_iter #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            mdu_req_i,
    input  logic [XLEN-1:0] mdu_port_a_i,
    input  logic [XLEN-1:0] mdu_port_b_i,
    input  logic [2:0]      mdu_op_i,
    input  logic            mdu_kill_i,
    input  logic            mdu_keep_i,
    output logic [XLEN-1:0] mdu_result_o,
    output logic            mdu_stall_req_o
);
    localparam int               DIV_ITERS = XLEN / DIV_BITS;
    localparam int               CNT_W     = $clog2(DIV_ITERS + 1);
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);
    localparam logic [XLEN-1:0]  XMIN      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2:0]       OP_MUL    = 3'd0;
    localparam logic [2:0]       OP_MULHU  = 3'd3;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    // High half for MULH*/REM*, low half for MUL/DIV*.
    function automatic logic sel_hi(input logic [2:0] op);
        return op[2] ? op[1] : (op != OP_MUL);
    endfunction

    state_t            r_state, w_next_state;
    logic              w_accept, w_div_special, w_mul_done, w_div_done, w_done;
    logic              w_cache_hit;
    logic [XLEN-1:0]   w_cache_val;
    logic [2:0]        r_op, w_done_op;
    logic [XLEN-1:0]   r_a, r_b, r_quo, r_rem, r_dvsr, r_result;
    logic              r_sign_a, r_sign_b;
    logic              w_in_sign_a, w_in_sign_b;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo_nxt, w_rem_nxt, w_quo_fix, w_rem_fix;
    logic [XLEN-1:0]   w_res_lo, w_res_hi, w_done_val;

    assign w_in_sign_a = mdu_port_a_i[XLEN-1] & (mdu_op_i[2] ? ~mdu_op_i[0] : (mdu_op_i != OP_MULHU));
    assign w_in_sign_b = mdu_port_b_i[XLEN-1] & (mdu_op_i[2] ? ~mdu_op_i[0] : ~mdu_op_i[1]);

    assign w_div_special = mdu_op_i[2] & ((mdu_port_b_i == '0) |
                           (~mdu_op_i[0] & (mdu_port_a_i == XMIN) & (mdu_port_b_i == '1)));

    // Sign-extending to 2*XLEN makes the modular product correct for every signedness mix.
    assign w_prod = {{XLEN{r_sign_a}}, r_a} * {{XLEN{r_sign_b}}, r_b};

    always_comb begin
        logic [XLEN:0] trial;
        // NOTE: every output gets a default first so no path can infer a latch.
        w_quo_nxt = r_quo;
        w_rem_nxt = r_rem;
        trial     = '0;
        for (int k = 0; k < DIV_BITS; k++) begin
            trial = {w_rem_nxt, w_quo_nxt[XLEN-1]} - {1'b0, r_dvsr};
            if (trial[XLEN]) w_rem_nxt = {w_rem_nxt[XLEN-2:0], w_quo_nxt[XLEN-1]};
            else             w_rem_nxt = trial[XLEN-1:0];
            w_quo_nxt = {w_quo_nxt[XLEN-2:0], ~trial[XLEN]};
        end
    end

    assign w_quo_fix = (r_sign_a ^ r_sign_b) ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_sign_a ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_next_state    = r_state;
        w_accept        = 1'b0;
        w_mul_done      = 1'b0;
        w_div_done      = 1'b0;
        mdu_stall_req_o = mdu_req_i & ~mdu_kill_i & (r_state != S_DONE) & ~w_cache_hit;
        case (r_state)
            S_IDLE: begin
                if (mdu_req_i && !mdu_kill_i && !w_cache_hit) begin
                    w_accept = 1'b1;
                    if (!mdu_op_i[2])       w_next_state = S_MUL;
                    else if (w_div_special) w_next_state = S_DONE;
                    else                    w_next_state = S_DIV;
                end
            end
            S_MUL: begin
                if (r_cnt == MUL_LAST) begin
                    w_mul_done   = ~mdu_kill_i;
                    w_next_state = S_DONE;
                end
            end
            S_DIV: begin
                if (r_cnt == DIV_LAST) begin
                    w_div_done   = ~mdu_kill_i;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (!mdu_keep_i) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (mdu_kill_i) w_next_state = S_IDLE;
    end

    assign w_done = (w_accept & w_div_special) | w_mul_done | w_div_done;

    // Both halves of whatever finishes this cycle: product, quotient/remainder or a special case.
    always_comb begin
        w_res_lo  = w_prod[XLEN-1:0];
        w_res_hi  = w_prod[2*XLEN-1:XLEN];
        w_done_op = r_op;
        if (w_accept) begin
            w_done_op = mdu_op_i;
            w_res_lo  = (mdu_port_b_i == '0) ? '1 : XMIN;
            w_res_hi  = (mdu_port_b_i == '0) ? mdu_port_a_i : '0;
        end else if (r_state == S_DIV) begin
            w_res_lo = w_quo_fix;
            w_res_hi = w_rem_fix;
        end
    end

    assign w_done_val = sel_hi(w_done_op) ? w_res_hi : w_res_lo;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (w_accept) begin
                r_op     <= mdu_op_i;
                r_a      <= mdu_port_a_i;
                r_b      <= mdu_port_b_i;
                r_sign_a <= w_in_sign_a;
                r_sign_b <= w_in_sign_b;
                r_quo    <= w_in_sign_a ? -mdu_port_a_i : mdu_port_a_i;
                r_dvsr   <= w_in_sign_b ? -mdu_port_b_i : mdu_port_b_i;
                r_rem    <= '0;
                r_cnt    <= '0;
            end else if (r_state == S_DIV) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_state == S_MUL) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done)           r_result <= w_done_val;
            else if (w_cache_hit) r_result <= w_cache_val;
        end
    end

`ifdef MIRISCV_MDU_RESULT_CACHE_EN
    function automatic logic [2:0] op_family(input logic [2:0] op);
        if (op[2]) return {2'b10, op[0]};
        return op[1] ? op : 3'd0;
    endfunction

    logic            r_c_valid;
    logic [XLEN-1:0] r_c_a, r_c_b, r_c_lo, r_c_hi;
    logic [2:0]      r_c_fam;

    assign w_cache_hit = (r_state == S_IDLE) & mdu_req_i & ~mdu_kill_i & r_c_valid &
                         (mdu_port_a_i == r_c_a) & (mdu_port_b_i == r_c_b) &
                         (op_family(mdu_op_i) == r_c_fam);
    assign w_cache_val = sel_hi(mdu_op_i) ? r_c_hi : r_c_lo;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_c_valid <= 1'b0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_lo    <= '0;
            r_c_hi    <= '0;
            r_c_fam   <= '0;
        end else if (w_done) begin
            r_c_valid <= 1'b1;
            r_c_a     <= w_accept ? mdu_port_a_i : r_a;
            r_c_b     <= w_accept ? mdu_port_b_i : r_b;
            r_c_fam   <= op_family(w_done_op);
            r_c_lo    <= w_res_lo;
            r_c_hi    <= w_res_hi;
        end else if (mdu_kill_i || w_accept) begin
            r_c_valid <= 1'b0;
        end
    end

    assign mdu_result_o = w_cache_hit ? w_cache_val : r_result;
`else
    assign w_cache_hit  = 1'b0;
    assign w_cache_val  = '0;
    assign mdu_result_o = r_result;
`endif

endmodule

// File: tb/tb_miriscv_mdu_iter.sv
// Randomized self-checking bench for miriscv_mdu_iter against an arithmetic reference model.
// Honours MIRISCV_MDU_RESULT_CACHE_EN when computing expected stall lengths.
module tb_miriscv_mdu_iter;
    localparam int          XLEN       = 32;
    localparam int          MUL_STAGES = 2;
    localparam int          DIV_BITS   = 1;
    localparam logic [31:0] MIN32      = 32'h8000_0000;
`ifdef MIRISCV_MDU_RESULT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        mdu_req_i, mdu_kill_i, mdu_keep_i;
    logic [31:0] mdu_port_a_i, mdu_port_b_i, mdu_result_o;
    logic [2:0]  mdu_op_i;
    logic        mdu_stall_req_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the last-result cache and of the last value the unit presented.
    bit          m_valid = 1'b0;
    logic [31:0] m_a, m_b, m_last;
    int          m_fam;

    miriscv_mdu_iter #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .DIV_BITS(DIV_BITS)) dut (
        .clk_i           (clk_i),
        .arstn_i         (arstn_i),
        .mdu_req_i       (mdu_req_i),
        .mdu_port_a_i    (mdu_port_a_i),
        .mdu_port_b_i    (mdu_port_b_i),
        .mdu_op_i        (mdu_op_i),
        .mdu_kill_i      (mdu_kill_i),
        .mdu_keep_i      (mdu_keep_i),
        .mdu_result_o    (mdu_result_o),
        .mdu_stall_req_o (mdu_stall_req_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint          sa, sb;
        longint unsigned ua, ub;
        bit              ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == MIN32) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return 32'(sa * sb);
            3'd1: return 32'((sa * sb) >>> 32);
            3'd2: return 32'((sa * longint'(ub)) >>> 32);
            3'd3: return 32'((ua * ub) >> 32);
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN32 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int family(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 0;
            3'd2:       return 1;
            3'd3:       return 2;
            3'd4, 3'd6: return 3;
            default:    return 4;
        endcase
    endfunction

    function automatic bit model_hit(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        return CACHE_EN && m_valid && (m_a == a) && (m_b == b) && (m_fam == family(op));
    endfunction

    function automatic int exp_cycles(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (model_hit(a, b, op)) return 0;
        if (op < 3'd4) return MUL_STAGES + 1;
        if (b == 0 || (op[0] == 1'b0 && a == MIN32 && b == 32'hFFFF_FFFF)) return 1;
        return XLEN / DIV_BITS + 1;
    endfunction

    function automatic void note_done(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                      input logic [31:0] res);
        m_valid = 1'b1;
        m_a     = a;
        m_b     = b;
        m_fam   = family(op);
        m_last  = res;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        mdu_port_a_i = a;
        mdu_port_b_i = b;
        mdu_op_i     = op;
        mdu_req_i    = 1'b1;
    endtask

    // Starts at a negedge with the request driven; counts stall cycles until stall drops.
    task automatic wait_result(output logic [31:0] res, output int cyc, input bit scramble);
        cyc = 0;
        #1;
        while (mdu_stall_req_o === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk_i);
            if (scramble) begin
                mdu_port_a_i = $urandom;
                mdu_port_b_i = $urandom;
                mdu_op_i     = 3'($urandom_range(0, 7));
            end
            #1;
        end
        res = mdu_result_o;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input string tag, input bit scramble);
        logic [31:0] exp_r, res;
        int          exp_c, cyc;
        exp_r = ref_result(a, b, op);
        exp_c = exp_cycles(a, b, op);
        issue(a, b, op);
        wait_result(res, cyc, scramble);
        check({tag, "_result"}, res, exp_r);
        check({tag, "_stall_cycles"}, cyc, exp_c);
        mdu_req_i = 1'b0;
        note_done(a, b, op, exp_r);
        @(negedge clk_i);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN32;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res, exp_r, ra, rb;
        int          cyc, exp_c;
        logic [2:0]  rop;

        arstn_i = 1'b0; mdu_req_i = 1'b0; mdu_kill_i = 1'b0; mdu_keep_i = 1'b0;
        mdu_port_a_i = '0; mdu_port_b_i = '0; mdu_op_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_result", mdu_result_o, 32'd0);
        check("reset_stall", mdu_stall_req_o, 1'b0);
        arstn_i = 1'b1;
        @(negedge clk_i);

        run_op(32'hFFFF_FFFF, 32'd2, 3'd0, "mul", 1'b0);
        run_op(32'hFFFF_FFFF, 32'd2, 3'd3, "mulhu", 1'b0);
        run_op(32'hFFFF_FFFF, 32'd2, 3'd1, "mulh", 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 3'd4, "div_neg", 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 3'd6, "rem_neg", 1'b0);
        run_op(32'd5, 32'd0, 3'd5, "divu_by0", 1'b0);
        run_op(32'd5, 32'd0, 3'd7, "remu_by0", 1'b0);
        run_op(MIN32, 32'hFFFF_FFFF, 3'd4, "div_ovf", 1'b0);
        run_op(MIN32, 32'hFFFF_FFFF, 3'd6, "rem_ovf", 1'b0);
        run_op(32'd100, 32'd7, 3'd4, "div_100_7", 1'b0);
        run_op(32'd100, 32'd7, 3'd6, "rem_100_7", 1'b0);

        // Hold a finished MUL with keep, then release it while the request stays high.
        mdu_keep_i = 1'b1;
        exp_r = ref_result(32'h1234_5678, 32'd3, 3'd0);
        exp_c = exp_cycles(32'h1234_5678, 32'd3, 3'd0);
        issue(32'h1234_5678, 32'd3, 3'd0);
        wait_result(res, cyc, 1'b0);
        check("keep_result", res, exp_r);
        check("keep_stall_cycles", cyc, exp_c);
        note_done(32'h1234_5678, 32'd3, 3'd0, exp_r);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            #1;
            check("keep_hold_stall", mdu_stall_req_o, 1'b0);
            check("keep_hold_result", mdu_result_o, exp_r);
        end
        @(negedge clk_i);
        mdu_keep_i = 1'b0;
        #1;
        check("keep_release_stall", mdu_stall_req_o, 1'b0);
        @(negedge clk_i);
        exp_c = exp_cycles(32'h1234_5678, 32'd3, 3'd0);
        wait_result(res, cyc, 1'b0);
        check("rereq_result", res, exp_r);
        check("rereq_stall_cycles", cyc, exp_c);
        mdu_req_i = 1'b0;
        @(negedge clk_i);

        // Kill a DIV at iteration 10; the old result must survive.
        issue(32'd1000, 32'd3, 3'd4);
        repeat (10) @(negedge clk_i);
        mdu_kill_i = 1'b1;
        #1;
        check("kill_stall", mdu_stall_req_o, 1'b0);
        check("kill_hold_result", mdu_result_o, m_last);
        @(negedge clk_i);
        mdu_kill_i = 1'b0;
        mdu_req_i  = 1'b0;
        m_valid    = 1'b0;
        #1;
        check("post_kill_stall", mdu_stall_req_o, 1'b0);
        check("post_kill_result", mdu_result_o, m_last);
        @(negedge clk_i);
        run_op(32'd100, 32'd7, 3'd5, "divu_after_kill", 1'b0);

        // Kill in the same cycle as a request accepts nothing.
        issue(32'd9, 32'd2, 3'd5);
        mdu_kill_i = 1'b1;
        #1;
        check("kill_req_stall", mdu_stall_req_o, 1'b0);
        @(negedge clk_i);
        mdu_kill_i = 1'b0;
        mdu_req_i  = 1'b0;
        m_valid    = 1'b0;
        @(negedge clk_i);
        run_op(32'd9, 32'd2, 3'd5, "divu_after_killreq", 1'b0);

        ra = rand_operand();
        rb = rand_operand();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                ra = rand_operand();
                rb = rand_operand();
            end
            rop = 3'($urandom_range(0, 7));
            run_op(ra, rb, rop, $sformatf("rand%0d", i), 1'b1);
        end

        // Asynchronous reset in the middle of a divide.
        run_op(32'd3, 32'd5, 3'd0, "pre_reset_mul", 1'b0);
        issue(32'd1000, 32'd3, 3'd4);
        repeat (5) @(negedge clk_i);
        #2;
        arstn_i = 1'b0;
        #1;
        check("async_reset_result", mdu_result_o, 32'd0);
        mdu_req_i = 1'b0;
        m_valid   = 1'b0;
        @(negedge clk_i);
        arstn_i = 1'b1;
        @(negedge clk_i);
        run_op(32'd100, 32'd7, 3'd5, "divu_after_reset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
